// File: rtl/tusca_pkg.sv
// ---------------------------------------------------------------------------
// tusca_pkg
//   Shared types and constants for the climate fan-level controller:
//   FSM state encoding, fan level range/width and a saturating level
//   increment helper.
// ---------------------------------------------------------------------------
package tusca_pkg;

    localparam int NIVEL_MAX = 4;
    localparam int NIVEL_W   = 3;

    typedef logic [NIVEL_W-1:0] nivel_t;

    typedef enum logic [1:0] {
        S_SEM_CONFIG = 2'd0,
        S_ESPERA     = 2'd1,
        S_AVALIA     = 2'd2,
        S_ATUALIZA   = 2'd3
    } estado_t;

    // Increment a level, clamping at NIVEL_MAX.
    function automatic nivel_t sat_inc(input nivel_t n);
        return (n >= nivel_t'(NIVEL_MAX)) ? nivel_t'(NIVEL_MAX) : n + nivel_t'(1);
    endfunction

endpackage

// File: rtl/climate_level_ctrl_if.sv
// ---------------------------------------------------------------------------
// climate_level_ctrl_if
//   Bundles the configuration, sample and fan-level signals of
//   climate_level_ctrl. Signal prefixes are from the controller's view.
//   Ports / signals:
//     i_pronto_config, i_erro_config   configuration pulses
//     i_temp_lim1..4, i_umidade_lim    limits (W bits, unsigned)
//     i_medida_valida, i_temperatura,
//     i_umidade                        sample strobe and data
//     o_nivel_ventilador (3), o_nivel_mudou, o_umid_alta,
//     o_em_operacao, o_amostra_descartada
//   Modports: master drives the i_* side (config manager / sensor / bench),
//             slave is the controller.
// ---------------------------------------------------------------------------
interface climate_level_ctrl_if
    import tusca_pkg::*;
#(
    parameter int W = 16
);

    logic         i_pronto_config;
    logic         i_erro_config;
    logic [W-1:0] i_temp_lim1;
    logic [W-1:0] i_temp_lim2;
    logic [W-1:0] i_temp_lim3;
    logic [W-1:0] i_temp_lim4;
    logic [W-1:0] i_umidade_lim;
    logic         i_medida_valida;
    logic [W-1:0] i_temperatura;
    logic [W-1:0] i_umidade;

    nivel_t       o_nivel_ventilador;
    logic         o_nivel_mudou;
    logic         o_umid_alta;
    logic         o_em_operacao;
    logic         o_amostra_descartada;

    modport master (
        output i_pronto_config, i_erro_config,
        output i_temp_lim1, i_temp_lim2, i_temp_lim3, i_temp_lim4, i_umidade_lim,
        output i_medida_valida, i_temperatura, i_umidade,
        input  o_nivel_ventilador, o_nivel_mudou, o_umid_alta,
        input  o_em_operacao, o_amostra_descartada
    );

    modport slave (
        input  i_pronto_config, i_erro_config,
        input  i_temp_lim1, i_temp_lim2, i_temp_lim3, i_temp_lim4, i_umidade_lim,
        input  i_medida_valida, i_temperatura, i_umidade,
        output o_nivel_ventilador, o_nivel_mudou, o_umid_alta,
        output o_em_operacao, o_amostra_descartada
    );

endinterface

// File: rtl/nivel_alvo_calc.sv
// ---------------------------------------------------------------------------
// nivel_alvo_calc
//   Combinational target fan level for one sample.
//     up  = number of limits with temp >= lim_k
//     dn  = number of limits with temp >= max(lim_k - HIST, 0)
//     tgt = up > lvl ? up : (dn < lvl ? dn : lvl)
//   Limits need not be ordered; all comparisons are unsigned.
//   Build option CLIMATE_HUM_BOOST_EN: when defined, humidity above its limit
//   adds one level (saturating at NIVEL_MAX) to both up and dn.
//   Ports:
//     i_temperatura, i_umidade  registered sample
//     i_temp_lim                four temperature limits (shadow copies)
//     i_umidade_lim             humidity limit (shadow copy)
//     i_nivel                   currently applied level
//     o_alvo                    target level
//     o_umid_alta               umidade > humidity limit
// ---------------------------------------------------------------------------
module nivel_alvo_calc
    import tusca_pkg::*;
#(
    parameter int W    = 16,
    parameter int HIST = 20
) (
    input  logic [W-1:0]        i_temperatura,
    input  logic [W-1:0]        i_umidade,
    input  logic [3:0][W-1:0]   i_temp_lim,
    input  logic [W-1:0]        i_umidade_lim,
    input  nivel_t              i_nivel,
    output nivel_t              o_alvo,
    output logic                o_umid_alta
);

    localparam logic [W-1:0] HIST_W = W'(HIST);

    logic [3:0]         w_ge_up;
    logic [3:0]         w_ge_dn;
    logic [3:0][W-1:0]  w_lim_dn;
    nivel_t             w_up;
    nivel_t             w_dn;
    nivel_t             w_up_b;
    nivel_t             w_dn_b;

    for (genvar k = 0; k < 4; k++) begin : g_lim
        // Lower threshold floors at zero instead of wrapping.
        assign w_lim_dn[k] = (i_temp_lim[k] > HIST_W) ? (i_temp_lim[k] - HIST_W) : '0;
        assign w_ge_up[k]  = (i_temperatura >= i_temp_lim[k]);
        assign w_ge_dn[k]  = (i_temperatura >= w_lim_dn[k]);
    end

    assign w_up        = nivel_t'($countones(w_ge_up));
    assign w_dn        = nivel_t'($countones(w_ge_dn));
    assign o_umid_alta = (i_umidade > i_umidade_lim);

`ifdef CLIMATE_HUM_BOOST_EN
    assign w_up_b = o_umid_alta ? sat_inc(w_up) : w_up;
    assign w_dn_b = o_umid_alta ? sat_inc(w_dn) : w_dn;
`else
    assign w_up_b = w_up;
    assign w_dn_b = w_dn;
`endif

    // Rise on the upper thresholds, fall only below the hysteresis band.
    always_comb begin
        if (w_up_b > i_nivel) begin
            o_alvo = w_up_b;
        end else if (w_dn_b < i_nivel) begin
            o_alvo = w_dn_b;
        end else begin
            o_alvo = i_nivel;
        end
    end

endmodule

// File: rtl/climate_level_ctrl.sv
// ---------------------------------------------------------------------------
// climate_level_ctrl
//   Latches temperature/humidity limits from the configuration manager and
//   converts each sensor sample into a fan level 0..4 using hysteresis and
//   N_PERSIST-sample persistence. Sample pipeline:
//     S_ESPERA (capture) -> S_AVALIA (target) -> S_ATUALIZA (persistence)
//   so a sample strobed at cycle t updates the outputs at t+2, and a new
//   sample can be taken every 3 cycles.
//   Build option CLIMATE_HUM_BOOST_EN (see nivel_alvo_calc): humidity above
//   its limit raises the target by one level.
//   Ports:
//     i_clock   system clock
//     i_reset   asynchronous reset, active low
//     io_bus    climate_level_ctrl_if.slave (config, sample, fan outputs)
// ---------------------------------------------------------------------------
module climate_level_ctrl
    import tusca_pkg::*;
#(
    parameter int W         = 16,
    parameter int HIST      = 20,
    parameter int N_PERSIST = 3
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    climate_level_ctrl_if.slave   io_bus
);

    localparam int CNT_W = (N_PERSIST < 1) ? 1 : $clog2(N_PERSIST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_PERSIST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    estado_t            r_estado;
    logic [3:0][W-1:0]  r_temp_lim;
    logic [W-1:0]       r_umidade_lim;
    logic [W-1:0]       r_temperatura;
    logic [W-1:0]       r_umidade;
    nivel_t             r_alvo;
    logic               r_umid_hi;
    nivel_t             r_nivel;
    nivel_t             r_cand;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_nivel_mudou;
    logic               r_umid_alta;
    logic               r_em_operacao;
    logic               r_descartada;

    nivel_t             w_alvo;
    logic               w_umid_alta;
    nivel_t             w_cand_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_troca;

    nivel_alvo_calc #(
        .W    (W),
        .HIST (HIST)
    ) u_alvo (
        .i_temperatura (r_temperatura),
        .i_umidade     (r_umidade),
        .i_temp_lim    (r_temp_lim),
        .i_umidade_lim (r_umidade_lim),
        .i_nivel       (r_nivel),
        .o_alvo        (w_alvo),
        .o_umid_alta   (w_umid_alta)
    );

    // Persistence step for the target registered in S_AVALIA.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_cnt;
        w_troca    = 1'b0;
        if (r_alvo == r_nivel) begin
            w_cnt_nxt = '0;
        end else begin
            if (r_alvo == r_cand) begin
                w_cnt_nxt = (r_cnt >= CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;
            end else begin
                w_cand_nxt = r_alvo;
                w_cnt_nxt  = CNT_ONE;
            end
            if (w_cnt_nxt >= CNT_MAX) begin
                w_troca   = 1'b1;
                w_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            // NOTE: limit shadows and sample registers are reset too, so an
            // unconfigured block never evaluates against X limits.
            r_estado      <= S_SEM_CONFIG;
            r_temp_lim    <= '0;
            r_umidade_lim <= '0;
            r_temperatura <= '0;
            r_umidade     <= '0;
            r_alvo        <= '0;
            r_umid_hi     <= 1'b0;
            r_nivel       <= '0;
            r_cand        <= '0;
            r_cnt         <= '0;
            r_nivel_mudou <= 1'b0;
            r_umid_alta   <= 1'b0;
            r_em_operacao <= 1'b0;
            r_descartada  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout: every read below sees
            // the pre-edge value, which is what keeps in-flight samples on the
            // old shadows when a new configuration lands in S_AVALIA.
            r_nivel_mudou <= 1'b0;
            r_descartada  <= io_bus.i_medida_valida && (r_estado != S_ESPERA);

            if (io_bus.i_erro_config) begin
                // Error wins over a simultaneous pronto_config: no latch.
                r_estado      <= S_SEM_CONFIG;
                r_em_operacao <= 1'b0;
                r_nivel       <= '0;
                r_cand        <= '0;
                r_cnt         <= '0;
                r_nivel_mudou <= (r_nivel != '0);
            end else begin
                if (io_bus.i_pronto_config) begin
                    r_temp_lim[0] <= io_bus.i_temp_lim1;
                    r_temp_lim[1] <= io_bus.i_temp_lim2;
                    r_temp_lim[2] <= io_bus.i_temp_lim3;
                    r_temp_lim[3] <= io_bus.i_temp_lim4;
                    r_umidade_lim <= io_bus.i_umidade_lim;
                end

                unique case (r_estado)
                    S_SEM_CONFIG: begin
                        if (io_bus.i_pronto_config) begin
                            r_estado      <= S_ESPERA;
                            r_em_operacao <= 1'b1;
                        end
                    end
                    S_ESPERA: begin
                        if (io_bus.i_medida_valida) begin
                            r_temperatura <= io_bus.i_temperatura;
                            r_umidade     <= io_bus.i_umidade;
                            r_estado      <= S_AVALIA;
                        end
                    end
                    S_AVALIA: begin
                        r_alvo    <= w_alvo;
                        r_umid_hi <= w_umid_alta;
                        r_estado  <= S_ATUALIZA;
                    end
                    S_ATUALIZA: begin
                        r_cand      <= w_cand_nxt;
                        r_cnt       <= w_cnt_nxt;
                        r_umid_alta <= r_umid_hi;
                        if (w_troca) begin
                            r_nivel       <= w_cand_nxt;
                            r_nivel_mudou <= 1'b1;
                        end
                        r_estado <= S_ESPERA;
                    end
                    default: r_estado <= S_SEM_CONFIG;
                endcase
            end
        end
    end

    assign io_bus.o_nivel_ventilador   = r_nivel;
    assign io_bus.o_nivel_mudou        = r_nivel_mudou;
    assign io_bus.o_umid_alta          = r_umid_alta;
    assign io_bus.o_em_operacao        = r_em_operacao;
    assign io_bus.o_amostra_descartada = r_descartada;

endmodule
